// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate scheduler slice.
//  gate_state_t : phases of the shared barrier sequence
//  gate_op_t    : what the car at the gate is doing (entering or leaving)
//  pool_t       : which free-space counter a transaction charges or credits
package parking_pkg;

  typedef enum logic [1:0] {IDLE, OPENING, PASSING, CLOSING} gate_state_t;
  typedef enum logic       {OP_ENTRY, OP_EXIT}               gate_op_t;
  typedef enum logic       {POOL_NORMAL, POOL_HANDI}         pool_t;

  localparam int DEF_NORMAL_CAP   = 10;
  localparam int DEF_HANDI_CAP    = 5;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_OPEN_CYCLES  = 4;
  localparam int DEF_PASS_TIMEOUT = 16;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Lane/gate side bundle of the parking gate scheduler.
//  master : lane sensors (requests, exit pool, car_passed) drive; status is observed
//  slave  : scheduler; drives gate_open, grants, space counters, lot_full, timeout_err
interface parking_gate_scheduler_if #(
  parameter int CNT_W = 4
);
  logic             req_normal;
  logic             req_handicap;
  logic             req_exit;
  logic             exit_is_handicap;
  logic             car_passed;
  logic             gate_open;
  logic             grant_normal;
  logic             grant_handicap;
  logic             grant_exit;
  logic [CNT_W-1:0] normal_spaces;
  logic [CNT_W-1:0] handicap_spaces;
  logic             lot_full;
  logic             timeout_err;

  modport master (
    output req_normal, req_handicap, req_exit, exit_is_handicap, car_passed,
    input  gate_open, grant_normal, grant_handicap, grant_exit,
           normal_spaces, handicap_spaces, lot_full, timeout_err
  );

  modport slave (
    input  req_normal, req_handicap, req_exit, exit_is_handicap, car_passed,
    output gate_open, grant_normal, grant_handicap, grant_exit,
           normal_spaces, handicap_spaces, lot_full, timeout_err
  );
endinterface

// File: rtl/gate_arbiter.sv
// Combinational fixed-priority pick (exit > handicap > normal) among eligible requests.
//  Inputs : request levels, exit pool select, current free-space counts
//  Outputs: one-hot win_* flags, win_any, and the {op, pool} the winner will commit to
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int NORMAL_CAP = DEF_NORMAL_CAP,
  parameter int HANDI_CAP  = DEF_HANDI_CAP,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             req_normal,
  input  logic             req_handicap,
  input  logic             req_exit,
  input  logic             exit_is_handicap,
  input  logic [CNT_W-1:0] normal_spaces,
  input  logic [CNT_W-1:0] handicap_spaces,
  output logic             win_normal,
  output logic             win_handicap,
  output logic             win_exit,
  output logic             win_any,
  output gate_op_t         win_op,
  output pool_t            win_pool
);

  logic elig_exit, elig_handi, elig_normal;

  // An exit may only credit a pool that is not already full; a handicap entry
  // may fall back to the normal pool when the handicap pool is exhausted.
  assign elig_exit   = exit_is_handicap ? (handicap_spaces < CNT_W'(HANDI_CAP))
                                        : (normal_spaces   < CNT_W'(NORMAL_CAP));
  assign elig_handi  = (handicap_spaces != '0) || (normal_spaces != '0);
  assign elig_normal = (normal_spaces != '0);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    win_normal   = 1'b0;
    win_handicap = 1'b0;
    win_exit     = 1'b0;
    win_op       = OP_ENTRY;
    win_pool     = POOL_NORMAL;
    if (req_exit && elig_exit) begin
      win_exit = 1'b1;
      win_op   = OP_EXIT;
      win_pool = exit_is_handicap ? POOL_HANDI : POOL_NORMAL;
    end else if (req_handicap && elig_handi) begin
      win_handicap = 1'b1;
      win_pool     = (handicap_spaces != '0) ? POOL_HANDI : POOL_NORMAL;
    end else if (req_normal && elig_normal) begin
      win_normal = 1'b1;
    end
  end

  assign win_any = win_exit | win_handicap | win_normal;

endmodule

// File: rtl/parking_gate_scheduler.sv
// Sequences the shared barrier gate and owns the normal/handicap free-space counters.
//  clk, reset : system clock, synchronous active-high reset
//  bus        : slave side of parking_gate_scheduler_if (requests and car_passed in;
//               gate_open, grant pulses, space counters, lot_full, timeout_err out)
// Counters change only when a car is seen passing; aborted or timed-out openings
// leave them untouched.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NORMAL_CAP   = DEF_NORMAL_CAP,
  parameter int HANDI_CAP    = DEF_HANDI_CAP,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
  input logic                     clk,
  input logic                     reset,
  parking_gate_scheduler_if.slave bus
);

  // State register kept as a plain vector so netlist names match older revisions.
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_OPENING = OPENING;
  localparam logic [1:0] ST_PASSING = PASSING;
  localparam logic [1:0] ST_CLOSING = CLOSING;

  // One timer serves all three timed phases; size it for the longest.
  localparam int TMAX  = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  gate_op_t         lat_op;
  pool_t            lat_pool;
  logic [CNT_W-1:0] n_q, h_q;

  logic     win_normal, win_handicap, win_exit, win_any;
  gate_op_t win_op;
  pool_t    win_pool;
  logic     in_idle, phase_done, pass_last, commit, timeout_hit;

  gate_arbiter #(
    .NORMAL_CAP (NORMAL_CAP),
    .HANDI_CAP  (HANDI_CAP),
    .CNT_W      (CNT_W)
  ) u_arb (
    .req_normal       (bus.req_normal),
    .req_handicap     (bus.req_handicap),
    .req_exit         (bus.req_exit),
    .exit_is_handicap (bus.exit_is_handicap),
    .normal_spaces    (n_q),
    .handicap_spaces  (h_q),
    .win_normal       (win_normal),
    .win_handicap     (win_handicap),
    .win_exit         (win_exit),
    .win_any          (win_any),
    .win_op           (win_op),
    .win_pool         (win_pool)
  );

  assign in_idle     = (state == ST_IDLE);
  assign phase_done  = (timer == TMR_W'(OPEN_CYCLES - 1));
  assign pass_last   = (timer == TMR_W'(PASS_TIMEOUT - 1));
  // A car seen on the final PASSING cycle still counts as a pass.
  assign commit      = (state == ST_PASSING) && bus.car_passed;
  assign timeout_hit = (state == ST_PASSING) && !bus.car_passed && pass_last;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked block with no
    // entry in the sensitivity list.
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      lat_op   <= OP_ENTRY;
      lat_pool <= POOL_NORMAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      unique case (state)
        ST_IDLE: begin
          if (win_any) begin
            state    <= ST_OPENING;
            timer    <= '0;
            lat_op   <= win_op;
            lat_pool <= win_pool;
          end
        end
        ST_OPENING: begin
          if (phase_done) begin
            state <= ST_PASSING;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_PASSING: begin
          if (commit || timeout_hit) begin
            state <= ST_CLOSING;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          if (phase_done) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

  // Eligibility at grant time guarantees these never saturate; the guards keep the
  // counters from wrapping even if that invariant were broken.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= CNT_W'(NORMAL_CAP);
      h_q <= CNT_W'(HANDI_CAP);
    end else if (commit) begin
      if (lat_op == OP_ENTRY) begin
        if (lat_pool == POOL_HANDI) begin
          assert (h_q != '0);
          if (h_q != '0) h_q <= h_q - 1'b1;
        end else begin
          assert (n_q != '0);
          if (n_q != '0) n_q <= n_q - 1'b1;
        end
      end else begin
        if (lat_pool == POOL_HANDI) begin
          assert (h_q < CNT_W'(HANDI_CAP));
          if (h_q < CNT_W'(HANDI_CAP)) h_q <= h_q + 1'b1;
        end else begin
          assert (n_q < CNT_W'(NORMAL_CAP));
          if (n_q < CNT_W'(NORMAL_CAP)) n_q <= n_q + 1'b1;
        end
      end
    end
  end

  assign bus.gate_open       = (state == ST_OPENING) || (state == ST_PASSING);
  assign bus.grant_normal    = in_idle && !reset && win_normal;
  assign bus.grant_handicap  = in_idle && !reset && win_handicap;
  assign bus.grant_exit      = in_idle && !reset && win_exit;
  assign bus.timeout_err     = timeout_hit && !reset;
  assign bus.normal_spaces   = n_q;
  assign bus.handicap_spaces = h_q;
  assign bus.lot_full        = (n_q == '0) && (h_q == '0);

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench for parking_gate_scheduler: directed scenarios plus random
// traffic, compared every cycle against a cycle-stamp transaction model.
module tb_parking_gate_scheduler;

  localparam int N_CAP = 10;
  localparam int H_CAP = 5;
  localparam int OPEN  = 4;
  localparam int PTO   = 16;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  parking_gate_scheduler_if #(.CNT_W(4)) bus ();

  parking_gate_scheduler #(
    .NORMAL_CAP   (N_CAP),
    .HANDI_CAP    (H_CAP),
    .CNT_W        (4),
    .OPEN_CYCLES  (OPEN),
    .PASS_TIMEOUT (PTO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a transaction is described by cycle stamps (grant cycle,
  // first PASSING cycle, resolve cycle, next idle cycle); outputs follow from
  // where the current cycle falls relative to those stamps.
  // ---------------------------------------------------------------------------
  int cyc        = 0;
  int idle_at    = 0;
  int pass_first = 0;
  int resolved   = -1;
  bit busy       = 0;
  bit m_valid    = 0;
  bit m_exit     = 0;
  bit m_ph       = 0;
  int mn         = N_CAP;
  int mh         = H_CAP;

  always @(negedge clk) begin : model
    bit e_gn, e_gh, e_ge, e_to, e_open, do_commit, win, w_exit, w_ph;
    e_gn = 0; e_gh = 0; e_ge = 0; e_to = 0; e_open = 0;
    do_commit = 0; win = 0; w_exit = 0; w_ph = 0;

    if (busy && resolved >= 0 && cyc >= idle_at) busy = 0;

    if (busy) begin
      e_open = (resolved < 0) || (cyc <= resolved);
      if (resolved < 0 && cyc >= pass_first) begin
        if (bus.car_passed) begin
          do_commit = 1;
          resolved  = cyc;
        end else if (cyc == pass_first + PTO - 1) begin
          e_to     = 1;
          resolved = cyc;
        end
        if (resolved >= 0) idle_at = resolved + OPEN + 1;
      end
    end else if (!reset) begin
      if (bus.req_exit && (bus.exit_is_handicap ? (mh < H_CAP) : (mn < N_CAP))) begin
        e_ge = 1; win = 1; w_exit = 1; w_ph = bus.exit_is_handicap;
      end else if (bus.req_handicap && (mh > 0 || mn > 0)) begin
        e_gh = 1; win = 1; w_exit = 0; w_ph = (mh > 0);
      end else if (bus.req_normal && mn > 0) begin
        e_gn = 1; win = 1; w_exit = 0; w_ph = 0;
      end
    end

    if (reset) begin
      e_gn = 0; e_gh = 0; e_ge = 0; e_to = 0;
    end

    if (m_valid) begin
      check("gate_open",       bus.gate_open,       e_open);
      check("grant_normal",    bus.grant_normal,    e_gn);
      check("grant_handicap",  bus.grant_handicap,  e_gh);
      check("grant_exit",      bus.grant_exit,      e_ge);
      check("timeout_err",     bus.timeout_err,     e_to);
      check("normal_spaces",   bus.normal_spaces,   mn);
      check("handicap_spaces", bus.handicap_spaces, mh);
      check("lot_full",        bus.lot_full,        (mn == 0 && mh == 0));
    end

    if (reset) begin
      busy = 0; mn = N_CAP; mh = H_CAP; m_valid = 1;
    end else begin
      if (do_commit) begin
        if (m_exit) begin
          if (m_ph) mh++; else mn++;
        end else begin
          if (m_ph) mh--; else mn--;
        end
      end
      if (win) begin
        busy = 1; pass_first = cyc + 1 + OPEN; resolved = -1;
        m_exit = w_exit; m_ph = w_ph;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, output int which);
    which = 0;
    for (int k = 0; k < 200 && which == 0; k++) begin
      @(negedge clk);
      if (bus.grant_exit)          which = 3;
      else if (bus.grant_handicap) which = 2;
      else if (bus.grant_normal)   which = 1;
    end
    if (which == 0) check({name, "_grant_wait"}, 0, 1);
  endtask

  // Raise the given requests, wait for a grant, then either pass a car on the
  // first PASSING cycle or let PASSING time out; returns on the next IDLE cycle.
  task automatic txn(input string name, input bit rn, input bit rh, input bit re,
                     input bit eih, input int exp_which, input bit car);
    int w;
    bus.req_normal = rn; bus.req_handicap = rh; bus.req_exit = re;
    bus.exit_is_handicap = eih;
    wait_grant(name, w);
    check({name, "_who"}, w, exp_which);
    tick();
    case (w)
      1: bus.req_normal   = 1'b0;
      2: bus.req_handicap = 1'b0;
      3: bus.req_exit     = 1'b0;
      default: ;
    endcase
    repeat (OPEN) tick();
    if (car) begin
      bus.car_passed = 1'b1;
      @(negedge clk);
      check({name, "_open_at_pass"}, bus.gate_open, 1);
      tick();
      bus.car_passed = 1'b0;
    end else begin
      repeat (PTO - 1) tick();
      @(negedge clk);
      check({name, "_to_pulse"}, bus.timeout_err, 1);
      tick();
      @(negedge clk);
      check({name, "_to_gate_low"}, bus.gate_open, 0);
      check({name, "_to_single"}, bus.timeout_err, 0);
      tick();
      repeat (OPEN - 1) tick();
      repeat (0) tick();
    end
    repeat (OPEN) tick();
    if (!car) begin
      // timeout branch already consumed one extra edge above
    end
  endtask

  initial begin
    int w, gcount;
    reset = 1'b1;
    bus.req_normal = 0; bus.req_handicap = 0; bus.req_exit = 0;
    bus.exit_is_handicap = 0; bus.car_passed = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_gate_open", bus.gate_open, 0);
    check("rst_normal",    bus.normal_spaces, 10);
    check("rst_handicap",  bus.handicap_spaces, 5);
    check("rst_lot_full",  bus.lot_full, 0);
    tick();

    // Single normal entry.
    txn("s1", 1, 0, 0, 0, 1, 1);
    check("s1_normal_9", bus.normal_spaces, 9);
    check("s1_model_9", mn, 9);

    // Priority: exit > handicap > normal.
    txn("pr_exit",  1, 1, 1, 0, 3, 1);
    txn("pr_handi", 1, 1, 0, 0, 2, 1);
    txn("pr_norm",  1, 0, 0, 0, 1, 1);
    check("pr_normal_9", bus.normal_spaces, 9);
    check("pr_handi_4",  bus.handicap_spaces, 4);

    // Drain handicap pool, then bring normal down to 3.
    for (int i = 0; i < 4; i++) txn("drain_h", 0, 1, 0, 0, 2, 1);
    for (int i = 0; i < 6; i++) txn("drain_n", 1, 0, 0, 0, 1, 1);
    check("pre_fb_h0", bus.handicap_spaces, 0);
    check("pre_fb_n3", bus.normal_spaces, 3);

    // Handicap entry falls back to the normal pool.
    txn("fallback", 0, 1, 0, 0, 2, 1);
    check("fb_n2", bus.normal_spaces, 2);
    check("fb_h0", bus.handicap_spaces, 0);

    // Fill the lot; entry requests must then be ignored.
    for (int i = 0; i < 2; i++) txn("fill", 1, 0, 0, 0, 1, 1);
    check("full_flag", bus.lot_full, 1);
    bus.req_normal = 1; bus.req_handicap = 1;
    gcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      gcount += bus.grant_normal + bus.grant_handicap + bus.grant_exit;
    end
    check("full_no_grants", gcount, 0);
    tick();
    txn("full_exit_h", 0, 0, 1, 1, 3, 1);
    check("fe_h1", bus.handicap_spaces, 1);
    check("fe_not_full", bus.lot_full, 0);

    // Reset during PASSING aborts with counters restored.
    bus.req_exit = 1; bus.exit_is_handicap = 0;
    wait_grant("rst_pass", w);
    check("rst_pass_who", w, 3);
    tick();
    bus.req_exit = 0;
    repeat (OPEN + 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rp_gate_low", bus.gate_open, 0);
    check("rp_n10", bus.normal_spaces, 10);
    check("rp_h5", bus.handicap_spaces, 5);
    tick();

    // Timeout: no car ever passes.
    txn("timeout", 1, 0, 0, 0, 1, 0);
    check("to_n10", bus.normal_spaces, 10);
    check("to_h5", bus.handicap_spaces, 5);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) bus.req_normal   = ~bus.req_normal;
      if ($urandom_range(0, 5) == 0) bus.req_handicap = ~bus.req_handicap;
      if ($urandom_range(0, 6) == 0) bus.req_exit     = ~bus.req_exit;
      if ($urandom_range(0, 3) == 0) bus.exit_is_handicap = ~bus.exit_is_handicap;
      bus.car_passed = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 0; bus.car_passed = 0;
    bus.req_normal = 0; bus.req_handicap = 0; bus.req_exit = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
